// File: rtl/multiplicador_seq_if.sv
// ============================================================================
// Module  : multiplicador_seq_if
// Brief   : Operand/result handshake bundle for the sequential multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multiplicador_seq_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   P;

  modport master (output start, A, B, input  ready, done, P);
  modport slave  (input  start, A, B, output ready, done, P);
endinterface

`default_nettype wire

// File: rtl/multiplicador_seq.sv
// ============================================================================
// Module  : multiplicador_seq
// Brief   : Shift-and-add unsigned multiplier, one add/shift per cycle.
//           Optional MULT_ZERO_BYPASS_EN skips iterations for zero operands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multiplicador_seq #(
  parameter int WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  multiplicador_seq_if.slave  mul_if
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   p_q;
  logic                 ready_q;
  logic                 done_q;
  logic [WIDTH:0]       sum_d;
  logic                 zero_op_d;

  // Carry-out lands in sum_d[WIDTH] and becomes the new accumulator MSB.
  assign sum_d = {1'b0, acc_hi_q} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op_d = (mul_if.A == '0) || (mul_if.B == '0);
`else
  assign zero_op_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_if.start) begin
            ready_q <= 1'b0;
            if (zero_op_d) begin
              state_q <= S_DONE;
              p_q     <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_CALC;
              mcand_q  <= mul_if.A;
              mplier_q <= mul_if.B;
              acc_hi_q <= '0;
              cnt_q    <= '0;
            end
          end
        end
        S_CALC: begin
          {acc_hi_q, mplier_q} <= {sum_d, mplier_q[WIDTH-1:1]};
          cnt_q                <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_DONE;
            p_q     <= {sum_d, mplier_q[WIDTH-1:1]};
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign mul_if.ready = ready_q;
  assign mul_if.done  = done_q;
  assign mul_if.P     = p_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplicador_seq.sv
// ============================================================================
// Module  : tb_multiplicador_seq
// Brief   : Directed vector bench for multiplicador_seq (WIDTH=4); honours
//           MULT_ZERO_BYPASS_EN for expected zero-operand latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multiplicador_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multiplicador_seq_if #(.WIDTH(W)) bus ();

  multiplicador_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mul_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs [8];

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] last_p = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_ZERO_BYPASS_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // Pulses start for one cycle and follows the operation to its done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input string name);
    int lat;
    bit ready_ok;
    bit hold_ok;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    ready_ok = 1'b1;
    hold_ok = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (bus.ready !== 1'b0) ready_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
      end else begin
        if (bus.P !== last_p) hold_ok = 1'b0;
        tick();
      end
    end
    check({name, " latency"}, lat, exp_latency(a, b));
    check({name, " P"}, {24'd0, bus.P}, {24'd0, exp_p});
    check({name, " ready low while busy"}, {31'd0, ready_ok}, 32'd1);
    check({name, " P held before done"}, {31'd0, hold_ok}, 32'd1);
    last_p = exp_p;
    tick();
    check({name, " done one cycle"}, {31'd0, bus.done}, 32'd0);
    check({name, " ready after done"}, {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    int cnt;
    int first;
    int second;

    vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'h8F};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[2] = '{a: 4'd1,  b: 4'd1,  p: 8'h01};
    vecs[3] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
    vecs[4] = '{a: 4'd9,  b: 4'd0,  p: 8'h00};
    vecs[5] = '{a: 4'd15, b: 4'd1,  p: 8'h0F};
    vecs[6] = '{a: 4'd6,  b: 4'd7,  p: 8'h2A};
    vecs[7] = '{a: 4'd8,  b: 4'd8,  p: 8'h40};

    // Reset with start asserted: must stay idle.
    bus.start = 1'b1;
    bus.A = 4'd5;
    bus.B = 4'd5;
    rst = 1'b1;
    tick();
    tick();
    check("reset P", {24'd0, bus.P}, 32'h0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset ready", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    check("idle after reset ready", {31'd0, bus.ready}, 32'd1);
    check("idle after reset done", {31'd0, bus.done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Second start during CALC is ignored.
    bus.A = 4'd3;
    bus.B = 4'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.A = 4'd7;
    bus.B = 4'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    first = 0;
    for (int k = 3; k <= 14; k++) begin
      if (bus.done === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first = k;
          check("ignored start P", {24'd0, bus.P}, 32'h0F);
        end
      end
      tick();
    end
    check("ignored start done count", cnt, 1);
    check("ignored start latency", first, W + 1);
    last_p = 8'h0F;

    // Reset in CALC cycle 3 aborts without a done pulse.
    bus.A = 4'd9;
    bus.B = 4'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", {31'd0, bus.ready}, 32'd1);
    check("abort P", {24'd0, bus.P}, 32'h0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done === 1'b1) cnt++;
      tick();
    end
    check("abort no done", cnt, 0);
    last_p = '0;
    run_op(4'd2, 4'd3, 8'h06, "after abort");

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    bus.A = 4'd2;
    bus.B = 4'd2;
    bus.start = 1'b1;
    first = 0;
    second = 0;
    for (int k = 1; k <= 20 && second == 0; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        if (first == 0) first = k;
        else second = k;
      end
    end
    bus.start = 1'b0;
    check("held start spacing", second - first, W + 2);
    check("held start P", {24'd0, bus.P}, 32'h04);
    for (int k = 0; k < 8; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
